// File: rtl/bp_me_cache_dma_arbiter.sv
// Shares one memory-side DMA channel among several cache banks: round-robin packet grant,
// write bursts locked to the granted bank, read fills steered in order by a tag FIFO.
// Define BP_ME_CACHE_DMA_ARB_FIXED_PRIO_EN for fixed priority (lowest bank index wins).
module bp_me_cache_dma_arbiter #(
   parameter int banks_p       = 2,
   parameter int addr_width_p  = 40,
   parameter int fill_width_p  = 64,
   parameter int block_width_p = 512,
   parameter int rd_tag_els_p  = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic [banks_p*(addr_width_p+1)-1:0]   bank_pkt_i,
   input  logic [banks_p-1:0]                    bank_pkt_v_i,
   output logic [banks_p-1:0]                    bank_pkt_ready_and_o,
   input  logic [banks_p*fill_width_p-1:0]       bank_wdata_i,
   input  logic [banks_p-1:0]                    bank_wdata_v_i,
   output logic [banks_p-1:0]                    bank_wdata_ready_and_o,
   output logic [fill_width_p-1:0]               bank_rdata_o,
   output logic [banks_p-1:0]                    bank_rdata_v_o,
   input  logic [banks_p-1:0]                    bank_rdata_ready_and_i,
   output logic [addr_width_p:0]                 dma_pkt_o,
   output logic                                  dma_pkt_v_o,
   input  logic                                  dma_pkt_ready_and_i,
   output logic [fill_width_p-1:0]               dma_wdata_o,
   output logic                                  dma_wdata_v_o,
   input  logic                                  dma_wdata_ready_and_i,
   input  logic [fill_width_p-1:0]               dma_rdata_i,
   input  logic                                  dma_rdata_v_i,
   output logic                                  dma_rdata_ready_and_o
);

   localparam int pkt_width_lp     = addr_width_p + 1;
   localparam int beats_lp         = block_width_p / fill_width_p;
   localparam int bank_id_width_lp = (banks_p > 1) ? $clog2(banks_p) : 1;
   localparam int beat_width_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam int tag_ptr_width_lp = (rd_tag_els_p > 1) ? $clog2(rd_tag_els_p) : 1;
   localparam int tag_cnt_width_lp = $clog2(rd_tag_els_p + 1);

   typedef enum logic {e_idle, e_wdata} state_e;

   state_e state_r, state_n;

   logic [bank_id_width_lp-1:0] wbank_r;
   logic [beat_width_lp-1:0]    wbeat_r;
   logic [beat_width_lp-1:0]    fbeat_r;
   logic [bank_id_width_lp-1:0] tag_mem_r [rd_tag_els_p];
   logic [tag_ptr_width_lp-1:0] tag_wptr_r, tag_rptr_r;
   logic [tag_cnt_width_lp-1:0] tag_cnt_r;

   logic [banks_p-1:0]          pkt_write, cand;
   logic                        grant_v;
   logic [bank_id_width_lp-1:0] grant_id;
   logic [bank_id_width_lp-1:0] head;
   logic                        tag_full, tag_empty;
   logic                        pkt_hs, wdata_hs, fill_hs, push, pop;
   logic                        wbeat_last, fbeat_last;

   assign tag_full   = (tag_cnt_r == tag_cnt_width_lp'(rd_tag_els_p));
   assign tag_empty  = (tag_cnt_r == '0);
   assign head       = tag_mem_r[tag_rptr_r];
   assign wbeat_last = (wbeat_r == beat_width_lp'(beats_lp - 1));
   assign fbeat_last = (fbeat_r == beat_width_lp'(beats_lp - 1));

   // Reads need a free tag slot; writes can always be granted.
   always_comb begin
      pkt_write = '0;
      cand      = '0;
      for (int i = 0; i < banks_p; i++) begin
         pkt_write[i] = bank_pkt_i[i*pkt_width_lp + addr_width_p];
         cand[i]      = bank_pkt_v_i[i] & (pkt_write[i] | ~tag_full);
      end
   end

`ifdef BP_ME_CACHE_DMA_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      for (int k = 0; k < banks_p; k++) begin
         if (!grant_v && cand[k]) begin
            grant_v  = 1'b1;
            grant_id = bank_id_width_lp'(k);
         end
      end
   end
`else
   logic [bank_id_width_lp-1:0] last_grant_r;
   int                          scan;

   always_comb begin
      grant_v  = 1'b0;
      grant_id = '0;
      scan     = 0;
      for (int k = 1; k <= banks_p; k++) begin
         scan = (int'(last_grant_r) + k) % banks_p;
         if (!grant_v && cand[scan]) begin
            grant_v  = 1'b1;
            grant_id = bank_id_width_lp'(scan);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         last_grant_r <= bank_id_width_lp'(banks_p - 1);
      else if (pkt_hs)
         last_grant_r <= grant_id;
   end
`endif

   assign pkt_hs   = dma_pkt_v_o & dma_pkt_ready_and_i;
   assign wdata_hs = dma_wdata_v_o & dma_wdata_ready_and_i;
   assign push     = pkt_hs & ~pkt_write[grant_id];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         state_r <= e_idle;
      else
         state_r <= state_n;
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         e_idle:  if (pkt_hs && pkt_write[grant_id]) state_n = e_wdata;
         e_wdata: if (wdata_hs && wbeat_last) state_n = e_idle;
         default: state_n = e_idle;
      endcase
   end

   // Outputs are held low while reset is asserted, even if banks keep requesting.
   always_comb begin
      dma_pkt_v_o            = 1'b0;
      bank_pkt_ready_and_o   = '0;
      dma_wdata_v_o          = 1'b0;
      bank_wdata_ready_and_o = '0;
      dma_pkt_o              = bank_pkt_i[grant_id*pkt_width_lp +: pkt_width_lp];
      dma_wdata_o            = bank_wdata_i[wbank_r*fill_width_p +: fill_width_p];
      if (reset_n_i) begin
         case (state_r)
            e_idle: begin
               if (grant_v) begin
                  dma_pkt_v_o                    = 1'b1;
                  bank_pkt_ready_and_o[grant_id] = dma_pkt_ready_and_i;
               end
            end
            e_wdata: begin
               dma_wdata_v_o                   = bank_wdata_v_i[wbank_r];
               bank_wdata_ready_and_o[wbank_r] = dma_wdata_ready_and_i;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wbank_r <= '0;
         wbeat_r <= '0;
      end else if (pkt_hs && pkt_write[grant_id]) begin
         wbank_r <= grant_id;
         wbeat_r <= '0;
      end else if (wdata_hs) begin
         wbeat_r <= wbeat_last ? '0 : wbeat_r + 1'b1;
      end
   end

   assign bank_rdata_o          = dma_rdata_i;
   assign dma_rdata_ready_and_o = ~tag_empty & bank_rdata_ready_and_i[head];
   assign fill_hs               = dma_rdata_v_i & dma_rdata_ready_and_o;
   assign pop                   = fill_hs & fbeat_last;

   always_comb begin
      bank_rdata_v_o = '0;
      if (dma_rdata_v_i && !tag_empty)
         bank_rdata_v_o[head] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push)
         tag_mem_r[tag_wptr_r] <= grant_id;
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tag_wptr_r <= '0;
         tag_rptr_r <= '0;
         tag_cnt_r  <= '0;
         fbeat_r    <= '0;
      end else begin
         if (push)
            tag_wptr_r <= (tag_wptr_r == tag_ptr_width_lp'(rd_tag_els_p - 1)) ? '0 : tag_wptr_r + 1'b1;
         if (pop)
            tag_rptr_r <= (tag_rptr_r == tag_ptr_width_lp'(rd_tag_els_p - 1)) ? '0 : tag_rptr_r + 1'b1;
         if (push && !pop)
            tag_cnt_r <= tag_cnt_r + 1'b1;
         else if (pop && !push)
            tag_cnt_r <= tag_cnt_r - 1'b1;
         if (fill_hs)
            fbeat_r <= fbeat_last ? '0 : fbeat_r + 1'b1;
      end
   end

endmodule
